// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states
// and the owner identifier.
package alu_arb_pkg;

   localparam logic [3:0] ALU_NOP   = 4'd0;
   localparam logic [3:0] ALU_ADD   = 4'd1;
   localparam logic [3:0] ALU_SUB   = 4'd2;
   localparam logic [3:0] ALU_NEGB  = 4'd3;
   localparam logic [3:0] ALU_NOTB  = 4'd4;
   localparam logic [3:0] ALU_AND   = 4'd5;
   localparam logic [3:0] ALU_OR    = 4'd6;
   localparam logic [3:0] ALU_XOR   = 4'd7;
   localparam logic [3:0] ALU_SRL   = 4'd8;
   localparam logic [3:0] ALU_SRA   = 4'd9;
   localparam logic [3:0] ALU_SLL   = 4'd10;
   localparam logic [3:0] ALU_ROR   = 4'd11;
   localparam logic [3:0] ALU_PASSB = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   typedef logic owner_t;

   localparam owner_t OWNER_0 = 1'b0;
   localparam owner_t OWNER_1 = 1'b1;

endpackage : alu_arb_pkg

// File: rtl/alu_share_arb_alu.sv
// Execute-stage ALU: purely combinational, results wrap modulo 2^DATA_W and
// shift amounts come from B[4:0]; unassigned opcodes produce zero.
module ALU
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic [OP_W-1:0]   i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_y
);

   logic        [4:0]        w_sh;
   logic signed [DATA_W-1:0] w_a_s;
   logic signed [DATA_W-1:0] w_sra;
   logic        [DATA_W-1:0] w_ror;

   assign w_sh  = i_b[4:0];
   assign w_a_s = $signed(i_a);
   assign w_sra = w_a_s >>> w_sh;
   // A zero rotate shifts left by the full width, which yields zero, so the OR keeps A intact.
   assign w_ror = (i_a >> w_sh) | (i_a << (DATA_W - int'(w_sh)));

   always_comb begin
      o_y = '0;
      case (i_op)
         OP_W'(ALU_NOP):   o_y = '0;
         OP_W'(ALU_ADD):   o_y = i_a + i_b;
         OP_W'(ALU_SUB):   o_y = i_a - i_b;
         OP_W'(ALU_NEGB):  o_y = '0 - i_b;
         OP_W'(ALU_NOTB):  o_y = ~i_b;
         OP_W'(ALU_AND):   o_y = i_a & i_b;
         OP_W'(ALU_OR):    o_y = i_a | i_b;
         OP_W'(ALU_XOR):   o_y = i_a ^ i_b;
         OP_W'(ALU_SRL):   o_y = i_a >> w_sh;
         OP_W'(ALU_SRA):   o_y = $unsigned(w_sra);
         OP_W'(ALU_SLL):   o_y = i_a << w_sh;
         OP_W'(ALU_ROR):   o_y = w_ror;
         OP_W'(ALU_PASSB): o_y = i_b;
         default:          o_y = '0;
      endcase
   end

endmodule : ALU

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters with exactly one operation in flight.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_arb
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ0_VALID,
   output logic              REQ0_READY,
   input  logic [OP_W-1:0]   REQ0_OP,
   input  logic [DATA_W-1:0] REQ0_A,
   input  logic [DATA_W-1:0] REQ0_B,
   input  logic              REQ1_VALID,
   output logic              REQ1_READY,
   input  logic [OP_W-1:0]   REQ1_OP,
   input  logic [DATA_W-1:0] REQ1_A,
   input  logic [DATA_W-1:0] REQ1_B,
   output logic              RSP0_VALID,
   output logic [DATA_W-1:0] RSP0_DATA,
   input  logic              RSP0_READY,
   output logic              RSP1_VALID,
   output logic [DATA_W-1:0] RSP1_DATA,
   input  logic              RSP1_READY
);

   arb_state_t        r_state;
   logic [OP_W-1:0]   r_op;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   owner_t            r_owner;
   logic [DATA_W-1:0] r_result;
   logic              r_rsp0_vld;
   logic              r_rsp1_vld;
`ifdef ALU_ARB_RR_EN
   owner_t            r_last;
`endif

   logic              w_idle;
   logic              w_win1;
   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_rsp_done;
   logic [DATA_W-1:0] w_alu_y;

   // Arbitration: grants are only offered in IDLE and never while reset is held.
   always_comb begin
      w_idle = (r_state == ST_IDLE) && !RST;
`ifdef ALU_ARB_RR_EN
      if (REQ0_VALID && REQ1_VALID) begin
         w_win1 = (r_last == OWNER_0);
      end else begin
         w_win1 = REQ1_VALID;
      end
`else
      w_win1 = REQ1_VALID && !REQ0_VALID;
`endif
      w_gnt0 = w_idle && REQ0_VALID && !w_win1;
      w_gnt1 = w_idle && REQ1_VALID && w_win1;
   end

   assign w_rsp_done = (r_rsp0_vld && RSP0_READY) || (r_rsp1_vld && RSP1_READY);

   assign REQ0_READY = w_gnt0;
   assign REQ1_READY = w_gnt1;
   assign RSP0_VALID = r_rsp0_vld;
   assign RSP1_VALID = r_rsp1_vld;
   assign RSP0_DATA  = r_result;
   assign RSP1_DATA  = r_result;

   ALU #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_alu (
      .i_op (r_op),
      .i_a  (r_a),
      .i_b  (r_b),
      .o_y  (w_alu_y)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= ST_IDLE;
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_owner    <= OWNER_0;
         r_result   <= '0;
         r_rsp0_vld <= 1'b0;
         r_rsp1_vld <= 1'b0;
`ifdef ALU_ARB_RR_EN
         r_last     <= OWNER_1;
`endif
      end else begin
         case (r_state)
            // IDLE: latch the winner's payload on the handshake
            ST_IDLE: begin
               if (w_gnt0 || w_gnt1) begin
                  r_op    <= w_gnt1 ? REQ1_OP : REQ0_OP;
                  r_a     <= w_gnt1 ? REQ1_A  : REQ0_A;
                  r_b     <= w_gnt1 ? REQ1_B  : REQ0_B;
                  r_owner <= owner_t'(w_gnt1);
`ifdef ALU_ARB_RR_EN
                  r_last  <= owner_t'(w_gnt1);
`endif
                  r_state <= ST_EXEC;
               end
            end
            // EXEC: capture the ALU output and raise the owner's response valid
            ST_EXEC: begin
               r_result   <= w_alu_y;
               r_rsp0_vld <= (r_owner == OWNER_0);
               r_rsp1_vld <= (r_owner == OWNER_1);
               r_state    <= ST_RESP;
            end
            // RESP: hold until the owner consumes the result
            ST_RESP: begin
               if (w_rsp_done) begin
                  r_rsp0_vld <= 1'b0;
                  r_rsp1_vld <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: begin
               r_rsp0_vld <= 1'b0;
               r_rsp1_vld <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : alu_share_arb

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: a transaction-level reference model
// checked every cycle, plus directed scenarios with literal expected results.
module tb_alu_share_arb;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
   logic              REQ0_READY, REQ1_READY;
   logic [OP_W-1:0]   REQ0_OP = '0, REQ1_OP = '0;
   logic [DATA_W-1:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
   logic              RSP0_VALID, RSP1_VALID;
   logic [DATA_W-1:0] RSP0_DATA, RSP1_DATA;
   logic              RSP0_READY = 1'b0, RSP1_READY = 1'b0;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   alu_share_arb #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP),
      .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
      .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP),
      .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
      .RSP0_VALID(RSP0_VALID), .RSP0_DATA(RSP0_DATA), .RSP0_READY(RSP0_READY),
      .RSP1_VALID(RSP1_VALID), .RSP1_DATA(RSP1_DATA), .RSP1_READY(RSP1_READY)
   );

   always #5 CLK = ~CLK;

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
      int s;
      s = int'(b[4:0]);
      case (op)
         1:  return a + b;
         2:  return a - b;
         3:  return 32'd0 - b;
         4:  return ~b;
         5:  return a & b;
         6:  return a | b;
         7:  return a ^ b;
         8:  return a >> s;
         9:  return $signed(a) >>> s;
         10: return a << s;
         11: return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
         12: return b;
         default: return 32'd0;
      endcase
   endfunction

   // Reference model: 0 = free, 1 = computing, 2 = presenting the result.
   int          m_stage = 0;
   int          m_owner = 0;
   int          m_last  = 1;
   bit          m_init  = 0;
   logic [31:0] m_res   = '0;
   logic [31:0] m_pend  = '0;

   initial forever begin
      bit e_r0, e_r1, take1;
      @(negedge CLK);
      if (RST) begin
         chk("model_rst_req0_ready", REQ0_READY, 0);
         chk("model_rst_req1_ready", REQ1_READY, 0);
         m_stage = 0; m_res = '0; m_last = 1; m_init = 1;
      end else if (m_init) begin
         e_r0 = 0; e_r1 = 0;
         if (m_stage == 0) begin
`ifdef ALU_ARB_RR_EN
            take1 = REQ1_VALID && (!REQ0_VALID || m_last == 0);
`else
            take1 = REQ1_VALID && !REQ0_VALID;
`endif
            e_r1 = take1;
            e_r0 = REQ0_VALID && !take1;
         end
         chk("model_req0_ready", REQ0_READY, e_r0);
         chk("model_req1_ready", REQ1_READY, e_r1);
         chk("model_rsp0_valid", RSP0_VALID, (m_stage == 2 && m_owner == 0));
         chk("model_rsp1_valid", RSP1_VALID, (m_stage == 2 && m_owner == 1));
         chk("model_rsp0_data", RSP0_DATA, m_res);
         chk("model_rsp1_data", RSP1_DATA, m_res);
         case (m_stage)
            0: if (e_r0 || e_r1) begin
               m_owner = e_r1 ? 1 : 0;
               m_last  = m_owner;
               m_pend  = e_r1 ? alu_ref(int'(REQ1_OP), REQ1_A, REQ1_B)
                              : alu_ref(int'(REQ0_OP), REQ0_A, REQ0_B);
               m_stage = 1;
            end
            1: begin m_res = m_pend; m_stage = 2; end
            default: if ((m_owner == 0) ? RSP0_READY : RSP1_READY) m_stage = 0;
         endcase
      end
   end

   task automatic send(input int p, input int op, input logic [31:0] a, input logic [31:0] b,
                       output int acc);
      bit got = 0;
      acc = -1;
      if (p == 0) begin REQ0_VALID = 1; REQ0_OP = OP_W'(op); REQ0_A = a; REQ0_B = b; end
      else        begin REQ1_VALID = 1; REQ1_OP = OP_W'(op); REQ1_A = a; REQ1_B = b; end
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge CLK);
         if ((p == 0) ? REQ0_READY : REQ1_READY) begin got = 1; acc = cyc; end
      end
      chk($sformatf("grant_p%0d_op%0d", p, op), got, 1);
      @(posedge CLK); #1;
      if (p == 0) REQ0_VALID = 0; else REQ1_VALID = 0;
   endtask

   task automatic wait_rsp(input int p, output int rc, output logic [31:0] d);
      bit got = 0;
      rc = -1; d = '0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge CLK);
         if (p == 0 ? (RSP0_VALID && RSP0_READY) : (RSP1_VALID && RSP1_READY)) begin
            got = 1; rc = cyc; d = (p == 0) ? RSP0_DATA : RSP1_DATA;
         end
      end
      chk($sformatf("response_p%0d", p), got, 1);
      @(posedge CLK); #1;
   endtask

   task automatic do_reset();
      RST = 1;
      @(posedge CLK); #1;
      RST = 0;
   endtask

   typedef struct { int op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
   vec_t vecs[$];

   int          acc, acc2, rc, a0, a0b, a1, r0, r0b, r1;
   logic [31:0] d, d0, d0b, d1;

   initial begin
      // Reset: a pending request must not be granted while reset is held.
      REQ0_VALID = 1; REQ0_OP = 4'd1; REQ0_A = 32'd1; REQ0_B = 32'd1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 0; REQ0_VALID = 0;
      @(negedge CLK);
      chk("reset_rsp0_valid", RSP0_VALID, 0);
      chk("reset_rsp1_valid", RSP1_VALID, 0);
      chk("reset_rsp0_data", RSP0_DATA, 0);
      chk("reset_rsp1_data", RSP1_DATA, 0);
      @(posedge CLK); #1;

      // Single add, then back-to-back readmission.
      RSP0_READY = 1;
      send(0, 1, 32'd5, 32'd7, acc);
      wait_rsp(0, rc, d);
      chk("add_data", d, 32'd12);
      chk("add_latency", rc - acc, 2);
      send(0, 5, 32'hFF00FF00, 32'h0FF00FF0, acc2);
      chk("readmit_cycle", acc2 - acc, 3);
      wait_rsp(0, rc, d);
      chk("and_data", d, 32'h0F000F00);

      // Opcode sweep with hand-computed results.
      vecs.push_back('{3,  32'h0,        32'h1,        32'hFFFFFFFF});
      vecs.push_back('{4,  32'h0,        32'h0F0F0F0F, 32'hF0F0F0F0});
      vecs.push_back('{8,  32'h80000000, 32'h24,       32'h08000000});
      vecs.push_back('{9,  32'h80000000, 32'h4,        32'hF8000000});
      vecs.push_back('{10, 32'h1,        32'd31,       32'h80000000});
      vecs.push_back('{12, 32'h1,        32'hDEADBEEF, 32'hDEADBEEF});
      vecs.push_back('{1,  32'hFFFFFFFF, 32'h2,        32'h00000001});
      vecs.push_back('{0,  32'h5,        32'h5,        32'h0});
      vecs.push_back('{15, 32'h5,        32'h5,        32'h0});
      foreach (vecs[i]) begin
         send(0, vecs[i].op, vecs[i].a, vecs[i].b, acc);
         wait_rsp(0, rc, d);
         chk($sformatf("vec%0d_op%0d", i, vecs[i].op), d, vecs[i].exp);
      end

      // Contention: fresh pointer, req0 re-requests while req1 is still waiting.
      do_reset();
      RSP0_READY = 1; RSP1_READY = 1;
      fork
         begin
            send(0, 2, 32'd10, 32'd3, a0);
            wait_rsp(0, r0, d0);
            send(0, 6, 32'h00FF, 32'h0F00, a0b);
            wait_rsp(0, r0b, d0b);
         end
         begin
            send(1, 7, 32'hF0F0F0F0, 32'hFFFF0000, a1);
            wait_rsp(1, r1, d1);
         end
      join
      chk("cont_sub_data", d0, 32'd7);
      chk("cont_xor_data", d1, 32'h0F0FF0F0);
      chk("cont_or_data", d0b, 32'h00000FFF);
`ifdef ALU_ARB_RR_EN
      chk("rr_req1_second", a1 - a0, 3);
      chk("rr_req0_third", a0b - a0, 6);
`else
      chk("fixed_req0_again", a0b - a0, 3);
      chk("fixed_req1_last", a1 - a0, 6);
`endif

      // Response backpressure on requester 1 with a waiting req0 and a toggling RSP0_READY.
      RSP1_READY = 0; RSP0_READY = 0;
      send(1, 11, 32'h80000001, 32'd1, acc);
      REQ0_VALID = 1; REQ0_OP = 4'd12; REQ0_A = 32'h0; REQ0_B = 32'h55;
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         RSP0_READY = ~RSP0_READY;
         @(negedge CLK);
         chk("bp_rsp1_valid", RSP1_VALID, 1);
         chk("bp_rsp1_data", RSP1_DATA, 32'hC0000000);
         chk("bp_no_grant", REQ0_READY, 0);
      end
      @(posedge CLK); #1;
      RSP1_READY = 1; RSP0_READY = 1;
      wait_rsp(1, rc, d);
      chk("bp_hold_cycles", rc - acc, 6);
      chk("bp_ror_data", d, 32'hC0000000);
      send(0, 12, 32'h0, 32'h55, acc);
      wait_rsp(0, rc, d);
      chk("passb_data", d, 32'h55);

      // Reset while in EXEC: the operation vanishes.
      send(0, 1, 32'd1, 32'd2, acc);
      RST = 1;
      @(posedge CLK); #1;
      RST = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("midrst_rsp0_valid", RSP0_VALID, 0);
         chk("midrst_rsp0_data", RSP0_DATA, 0);
      end
      @(posedge CLK); #1;
      send(0, 1, 32'd100, 32'd23, acc);
      wait_rsp(0, rc, d);
      chk("post_reset_add", d, 32'd123);

      // Illegal opcode completes normally with zero.
      send(0, 14, 32'h1234, 32'h5678, acc);
      wait_rsp(0, rc, d);
      chk("illegal_data", d, 32'h0);
      chk("illegal_latency", rc - acc, 2);

      repeat (3) @(posedge CLK);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_err);
      $fatal(1, "watchdog");
   end

endmodule : tb_alu_share_arb
